// File: rtl/alu_issue_stage.sv
// alu_issue_stage: ALU issue register with a 2-entry skid buffer, hazard interlock and flush; `ALU_ISSUE_FWD_EN enables EX/MEM and MEM/WB forwarding
module alu_issue_stage #(
    parameter int XLEN = 32,
    parameter int OPW  = 4,
    parameter int RW   = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [RW-1:0]   in_rs1_idx,
    input  logic [RW-1:0]   in_rs2_idx,
    input  logic [XLEN-1:0] in_rs1_val,
    input  logic [XLEN-1:0] in_rs2_val,
    input  logic [XLEN-1:0] in_imm,
    input  logic            in_sel_a,
    input  logic            in_sel_b,
    input  logic [OPW-1:0]  in_alu_op,
    input  logic [RW-1:0]   in_rd,
    input  logic            in_rd_we,
    input  logic            exm_we,
    input  logic            exm_is_load,
    input  logic [RW-1:0]   exm_rd,
    input  logic [XLEN-1:0] exm_data,
    input  logic            mwb_we,
    input  logic [RW-1:0]   mwb_rd,
    input  logic [XLEN-1:0] mwb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] op_a,
    output logic [XLEN-1:0] op_b,
    output logic [OPW-1:0]  out_alu_op,
    output logic [RW-1:0]   out_rd,
    output logic            out_rd_we,
    output logic [XLEN-1:0] out_pc
);
    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] pc;
        logic [OPW-1:0]  op;
        logic [RW-1:0]   rd;
        logic            rd_we;
    } entry_t;

    entry_t main_q, skid_q, new_e;
    logic main_v, skid_v, hazard, accept, drain, use_a, use_b;
    logic [XLEN-1:0] rs1_r, rs2_r;

    assign use_a = ~in_sel_a && in_rs1_idx != '0;
    assign use_b = ~in_sel_b && in_rs2_idx != '0;

`ifdef ALU_ISSUE_FWD_EN
    function automatic logic [XLEN-1:0] fwd(input logic [RW-1:0] r, input logic [XLEN-1:0] rf);
        return (r == '0) ? '0 : (exm_we && exm_rd == r) ? exm_data : (mwb_we && mwb_rd == r) ? mwb_data : rf;
    endfunction
    assign rs1_r  = fwd(in_rs1_idx, in_rs1_val);
    assign rs2_r  = fwd(in_rs2_idx, in_rs2_val);
    assign hazard = exm_we && exm_is_load &&
                    ((use_a && exm_rd == in_rs1_idx) || (use_b && exm_rd == in_rs2_idx));
`else
    function automatic logic dep(input logic [RW-1:0] r);
        return (exm_we && exm_rd == r) || (mwb_we && mwb_rd == r);
    endfunction
    logic unused_fwd;
    assign unused_fwd = ^{exm_is_load, exm_data, mwb_data};
    assign rs1_r  = (in_rs1_idx == '0) ? '0 : in_rs1_val;
    assign rs2_r  = (in_rs2_idx == '0) ? '0 : in_rs2_val;
    assign hazard = (use_a && dep(in_rs1_idx)) || (use_b && dep(in_rs2_idx));
`endif

    always_comb begin
        new_e.a     = in_sel_a ? in_pc : rs1_r;
        new_e.b     = in_sel_b ? in_imm : rs2_r;
        new_e.pc    = in_pc;
        new_e.op    = in_alu_op;
        new_e.rd    = in_rd;
        new_e.rd_we = in_rd_we;
    end

    assign in_ready = ~skid_v && ~hazard && rst_n && ~flush;
    assign accept   = in_valid && in_ready;
    assign drain    = main_v && out_ready;

    // skid is only ever occupied behind a valid main entry, so an empty main implies an empty skid
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
            main_q <= '0;
            skid_q <= '0;
        end else if (flush) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
        end else if (!main_v || drain) begin
            main_v <= skid_v || accept;
            skid_v <= 1'b0;
            if (skid_v) main_q <= skid_q;
            else if (accept) main_q <= new_e;
        end else if (accept) begin
            skid_q <= new_e;
            skid_v <= 1'b1;
        end
    end

    assign out_valid  = main_v;
    assign op_a       = main_q.a;
    assign op_b       = main_q.b;
    assign out_pc     = main_q.pc;
    assign out_alu_op = main_q.op;
    assign out_rd     = main_q.rd;
    assign out_rd_we  = main_q.rd_we;
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed vector table plus hand-written handshake, backpressure, flush and reset sequences
module tb_alu_issue_stage;
    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, in_sel_a, in_sel_b, in_rd_we;
    logic [31:0] in_pc, in_rs1_val, in_rs2_val, in_imm, exm_data, mwb_data, op_a, op_b, out_pc;
    logic [4:0]  in_rs1_idx, in_rs2_idx, in_rd, exm_rd, mwb_rd, out_rd;
    logic [3:0]  in_alu_op, out_alu_op;
    logic        exm_we, exm_is_load, mwb_we, out_valid, out_ready, out_rd_we;

    alu_issue_stage dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_rs1_idx(in_rs1_idx), .in_rs2_idx(in_rs2_idx),
        .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_imm(in_imm),
        .in_sel_a(in_sel_a), .in_sel_b(in_sel_b), .in_alu_op(in_alu_op), .in_rd(in_rd),
        .in_rd_we(in_rd_we), .exm_we(exm_we), .exm_is_load(exm_is_load), .exm_rd(exm_rd),
        .exm_data(exm_data), .mwb_we(mwb_we), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
        .out_valid(out_valid), .out_ready(out_ready), .op_a(op_a), .op_b(op_b),
        .out_alu_op(out_alu_op), .out_rd(out_rd), .out_rd_we(out_rd_we), .out_pc(out_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rs1, rs2, rd, exm_rd, mwb_rd;
        logic [31:0] v1, v2, imm, pc, exm_data, mwb_data;
        logic        sel_a, sel_b, exm_we, exm_ld, mwb_we;
        logic [3:0]  op;
        logic        exp_ready;
        logic [31:0] exp_a, exp_b;
    } vec_t;

    int n_chk = 0;
    int n_fail = 0;
    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] v1, input logic [31:0] v2);
        vec_t v;
        v = '{rs1: 5'd1, rs2: 5'd2, rd: 5'd9, exm_rd: 5'd0, mwb_rd: 5'd0,
              v1: v1, v2: v2, imm: 32'h0, pc: 32'h1000, exm_data: 32'h0, mwb_data: 32'h0,
              sel_a: 1'b0, sel_b: 1'b0, exm_we: 1'b0, exm_ld: 1'b0, mwb_we: 1'b0,
              op: 4'h3, exp_ready: 1'b1, exp_a: v1, exp_b: v2};
        return v;
    endfunction

    task automatic drive(input vec_t v, input logic valid);
        in_valid = valid; in_rs1_idx = v.rs1; in_rs2_idx = v.rs2; in_rs1_val = v.v1;
        in_rs2_val = v.v2; in_imm = v.imm; in_pc = v.pc; in_sel_a = v.sel_a; in_sel_b = v.sel_b;
        in_alu_op = v.op; in_rd = v.rd; in_rd_we = 1'b1; exm_we = v.exm_we; exm_is_load = v.exm_ld;
        exm_rd = v.exm_rd; exm_data = v.exm_data; mwb_we = v.mwb_we; mwb_rd = v.mwb_rd;
        mwb_data = v.mwb_data;
    endtask

    initial begin
        vec_t v;
        tbl[0] = mk(32'd5, 32'd7);
        v = mk(32'h11, 32'h22); v.sel_a = 1; v.sel_b = 1; v.pc = 32'h100; v.imm = 32'h20;
        v.op = 4'h7; v.exp_a = 32'h100; v.exp_b = 32'h20; tbl[1] = v;
        v = mk(32'h33, 32'h55); v.rs1 = 3; v.rs2 = 0; v.exm_we = 1; v.exm_rd = 3; v.exm_data = 32'hAA;
        v.mwb_we = 1; v.mwb_rd = 3; v.mwb_data = 32'hBB;
`ifdef ALU_ISSUE_FWD_EN
        v.exp_a = 32'hAA; v.exp_b = 32'h0;
`else
        v.exp_ready = 0;
`endif
        tbl[2] = v;
        v = mk(32'h77, 32'h44); v.rs1 = 0; v.exm_we = 1; v.exm_rd = 0; v.exm_data = 32'hAA;
        v.exp_a = 32'h0; tbl[3] = v;
        v = mk(32'h5, 32'h66); v.rs2 = 4; v.exm_we = 1; v.exm_ld = 1; v.exm_rd = 4; v.exp_ready = 0;
        tbl[4] = v;
        v = mk(32'h5, 32'h66); v.rs2 = 4; v.exm_we = 1; v.exm_ld = 1; v.exm_rd = 4; v.sel_b = 1;
        v.imm = 32'h9; v.exp_b = 32'h9; tbl[5] = v;
        v = mk(32'h1, 32'h11); v.rs2 = 6; v.mwb_we = 1; v.mwb_rd = 6; v.mwb_data = 32'hCC;
`ifdef ALU_ISSUE_FWD_EN
        v.exp_b = 32'hCC;
`else
        v.exp_ready = 0;
`endif
        tbl[6] = v;
        v = mk(32'h1234, 32'h2); v.rs1 = 8; v.exm_rd = 8; v.exm_data = 32'hDEAD; tbl[7] = v;
        v = mk(32'h1, 32'h2); v.sel_a = 1; v.pc = 32'h2000; v.exm_we = 1; v.exm_ld = 1; v.exm_rd = 1;
        v.exp_a = 32'h2000; tbl[8] = v;
        v = mk(32'hFFFF_FFFF, 32'h8000_0000); v.rs1 = 31; v.rs2 = 30; v.op = 4'hF; v.rd = 0;
        tbl[9] = v;

        rst_n = 0; flush = 0; out_ready = 1; drive(mk(1, 2), 1'b1);
        @(negedge clk); #1 chk("reset_in_ready", {31'b0, in_ready}, 0);
        @(posedge clk); #1
        chk("reset_out_valid", {31'b0, out_valid}, 0);
        chk("reset_op_a", op_a, 0); chk("reset_op_b", op_b, 0); chk("reset_pc", out_pc, 0);
        chk("reset_fields", {22'b0, out_alu_op, out_rd, out_rd_we}, 0);
        @(negedge clk); rst_n = 1; in_valid = 0;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk); drive(tbl[i], 1'b1);
            #1 chk($sformatf("vec%0d_in_ready", i), {31'b0, in_ready}, {31'b0, tbl[i].exp_ready});
            @(posedge clk); #1
            chk($sformatf("vec%0d_out_valid", i), {31'b0, out_valid}, {31'b0, tbl[i].exp_ready});
            if (tbl[i].exp_ready) begin
                chk($sformatf("vec%0d_op_a", i), op_a, tbl[i].exp_a);
                chk($sformatf("vec%0d_op_b", i), op_b, tbl[i].exp_b);
                chk($sformatf("vec%0d_fields", i), {out_pc[22:0], out_alu_op, out_rd},
                    {tbl[i].pc[22:0], tbl[i].op, tbl[i].rd});
            end
        end
        @(negedge clk); in_valid = 0;
        @(negedge clk);

        for (int i = 0; i < 3; i++) begin
            drive(mk(32'h100 + i, 32'h0), 1'b1);
            @(posedge clk); #1 chk($sformatf("tput%0d_op_a", i), op_a, 32'h100 + i);
            chk($sformatf("tput%0d_valid", i), {31'b0, out_valid}, 1);
            @(negedge clk);
        end
        in_valid = 0;
        @(negedge clk);

        out_ready = 0;
        drive(mk(32'h10, 32'h0), 1'b1); #1 chk("bp_ready0", {31'b0, in_ready}, 1);
        @(negedge clk); drive(mk(32'h20, 32'h0), 1'b1); #1 chk("bp_ready1", {31'b0, in_ready}, 1);
        @(negedge clk); drive(mk(32'h30, 32'h0), 1'b1); #1 chk("bp_ready2", {31'b0, in_ready}, 0);
        chk("bp_hold_a", op_a, 32'h10);
        @(posedge clk); #1 chk("bp_hold_a2", op_a, 32'h10); chk("bp_valid", {31'b0, out_valid}, 1);
        @(negedge clk); in_valid = 0; out_ready = 1;
        @(posedge clk); #1 chk("bp_order1", op_a, 32'h20); chk("bp_v1", {31'b0, out_valid}, 1);
        @(posedge clk); #1 chk("bp_drained", {31'b0, out_valid}, 0);

        @(negedge clk); out_ready = 0;
        drive(mk(32'h40, 32'h0), 1'b1);
        @(negedge clk); drive(mk(32'h50, 32'h0), 1'b1);
        @(negedge clk); drive(mk(32'h60, 32'h0), 1'b1); flush = 1;
        #1 chk("flush_in_ready", {31'b0, in_ready}, 0);
        @(negedge clk); flush = 0; in_valid = 0;
        #1 chk("flush_out_valid", {31'b0, out_valid}, 0); chk("flush_ready_after", {31'b0, in_ready}, 1);
        out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1 chk($sformatf("flush_quiet%0d", i), {31'b0, out_valid}, 0);
        end

        @(negedge clk); drive(mk(32'h70, 32'h0), 1'b1); out_ready = 0;
        @(negedge clk); in_valid = 0; rst_n = 0;
        @(posedge clk); #1 chk("midrst_valid", {31'b0, out_valid}, 0); chk("midrst_op_a", op_a, 0);
        @(negedge clk); rst_n = 1; out_ready = 1;
        @(posedge clk); #1 chk("midrst_quiet", {31'b0, out_valid}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Execute-stage issue register for the RV32 core. It sits directly upstream of the combinational ALU and captures decoded instructions from the decode stage. It selects and forwards the two ALU operands and presents them, registered, on `op_a`/`op_b`. It implements a valid/ready handshake with a 2-entry skid buffer, load-use interlock, and pipeline flush.

## Interface
Parameters:
- XLEN, 32, datapath width
- OPW, 4, ALU operation code width
- RW, 5, register index width

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  synchronous, active-low reset
- flush  in  1  discard all buffered and incoming instructions
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  stage accepts this cycle; accept = in_valid & in_ready
- in_pc  in  XLEN  instruction PC
- in_rs1_idx, in_rs2_idx  in  RW  source register indices
- in_rs1_val, in_rs2_val  in  XLEN  register-file read data
- in_imm  in  XLEN  sign-extended immediate
- in_sel_a  in  1  0: rs1, 1: pc
- in_sel_b  in  1  0: rs2, 1: imm
- in_alu_op  in  OPW  ALU operation, passed through
- in_rd  in  RW  destination index
- in_rd_we  in  1  destination write enable
- exm_we, exm_is_load  in  1  EX/MEM stage writes rd / is a load
- exm_rd  in  RW; exm_data  in  XLEN  EX/MEM result
- mwb_we  in  1; mwb_rd  in  RW; mwb_data  in  XLEN  MEM/WB result
- out_valid  out  1  operands valid to ALU/EX
- out_ready  in  1  EX consumes this cycle
- op_a, op_b  out  XLEN  ALU operands
- out_alu_op  out  OPW; out_rd  out  RW; out_rd_we  out  1; out_pc  out  XLEN  passed-through fields

## Operation
- Operand resolution happens at accept time. For each source with index r ≠ 0, the value is chosen in priority order:
  - exm_data if exm_we & exm_rd == r
  - else mwb_data if mwb_we & mwb_rd == r
  - else the register-file read value.
- Index 0 always resolves to 0 and is never forwarded.
- Operand selection: op_a = in_sel_a ? in_pc : resolved rs1; op_b = in_sel_b ? in_imm : resolved rs2. Only sources actually used (sel = 0) participate in hazard detection.
- Load-use hazard: a used source matches exm_rd with exm_we & exm_is_load and index ≠ 0.
- in_ready = ~skid_full & ~hazard & rst_n & ~flush.
- Buffer: a main entry drives the outputs; a skid entry is filled only when accept occurs while the main entry is valid and out_ready = 0.
  - When the main entry drains, the skid entry moves to main.
  - Order is strictly FIFO.
- Simultaneous accept and drain with skid empty: the new entry replaces main directly, giving 1 instruction per cycle of throughput.
- flush: next cycle both entries are invalid. Any instruction presented in the flush cycle is dropped. Flush beats accept.

## Timing
- Latency: accept in cycle N → out_valid = 1 with its operands in cycle N+1, provided no older entry is pending.
- Handshake hold: while out_valid & ~out_ready, all out_* and op_a/op_b hold stable.
- Backpressure: in_ready falls only once the skid entry is full, i.e. 2 entries are held.
- Reset (rst_n = 0 at a clock edge), effective next cycle:
  - out_valid = 0; op_a, op_b, out_pc = 0; out_alu_op = 0; out_rd = 0; out_rd_we = 0.
  - Both entries are empty.
  - in_ready is 0 while rst_n = 0.
- Reset mid-operation discards buffered entries exactly as flush does.
- Hazard stall persists combinationally each cycle until the matching load leaves EX/MEM. Decode must hold its inputs stable meanwhile.

## Configuration
- Macro: ALU_ISSUE_FWD_EN.
- Defined: EX/MEM and MEM/WB forwarding as above; only load-use stalls.
- Undefined:
  - No forwarding muxes; operands always come from register-file values.
  - hazard is asserted for any used source (≠0) matching exm_rd with exm_we, or mwb_rd with mwb_we.
  - The stall lasts until writeback has completed, which takes 2 cycles for a back-to-back dependency.

## Test plan
- Reset then single issue: in_rs1_val = 5, in_rs2_val = 7, sel = 0/0, accept at cycle N → out_valid at N+1 with op_a = 5, op_b = 7; out_valid = 0 and in_ready = 0 during reset.
- Forwarding priority: rs1 = 3 with exm_rd = 3 (exm_data = 0xAA) and mwb_rd = 3 (mwb_data = 0xBB) → op_a = 0xAA. With rs1 = 0 and exm_rd = 0 → op_a = 0. (Macro undefined: in_ready = 0 instead.)
- Load-use: exm_is_load = 1, exm_rd = 4, rs2 = 4, sel_b = 0 → in_ready = 0 for that cycle. With sel_b = 1 (imm) → accepted.
- Backpressure: out_ready = 0, three back-to-back valid inputs → two accepted, in_ready = 0 on the third. Release out_ready → outputs appear in order, one per cycle.
- Flush with both entries full plus in_valid = 1 → next cycle out_valid = 0 and in_ready = 1; no flushed instruction ever appears at the output.
